// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single-port data memory. Port 0 is the load/store path
// and port 1 is the loader/debug port. Each transaction takes one ACCESS cycle and one RESP cycle.
module dmem_port_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic          we1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err0,
  output logic          err1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0] LOCK_MAX_C = LW'(MAX_LOCK);
  localparam logic [LW-1:0] LOCK_ONE_C = LW'(1);
  localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_C);
  endfunction

  state_t        state_r, state_s;
  logic          owner_r, owner_s, last_r;
  logic [AW-1:0] addr_r, addr_s;
  logic          we_r, we_s;
  logic [DW-1:0] wdata_r, wdata_s;
  logic [LW-1:0] lock_cnt_r, lock_cnt_s;
  logic          cand0_s, cand1_s, lock_win_s, grant_s, win_s;
  logic          gnt0_r, gnt1_r, ack0_r, ack1_r, err0_r, err1_r;
  logic          mem_en_r, mem_we_r, busy_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;

  // Winner selection. In RESP the acked port's still-high request is ignored,
  // and an active lock keeps port 0 out so the flow drops through IDLE.
  always_comb begin
    cand0_s    = req0 && !(state_r == RESP && owner_r == 1'b0);
    cand1_s    = req1 && !(state_r == RESP && owner_r == 1'b1);
    lock_win_s = owner_r && lock1 && req1 && (lock_cnt_r < LOCK_MAX_C);
    grant_s    = 1'b0;
    win_s      = 1'b0;
    if (state_r == ACCESS) begin
      grant_s = 1'b0;
    end else if (lock_win_s) begin
      grant_s = cand1_s;
      win_s   = 1'b1;
    end else if (cand0_s && cand1_s) begin
      grant_s = 1'b1;
      win_s   = ~last_r;
    end else if (cand0_s || cand1_s) begin
      grant_s = 1'b1;
      win_s   = cand1_s;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Next state, latched transaction and lock counter
  always_comb begin
    state_s    = IDLE;
    owner_s    = owner_r;
    addr_s     = addr_r;
    we_s       = we_r;
    wdata_s    = wdata_r;
    lock_cnt_s = lock_cnt_r;
    case (state_r)
      IDLE:    state_s = grant_s ? ACCESS : IDLE;
      ACCESS:  state_s = RESP;
      RESP:    state_s = grant_s ? ACCESS : IDLE;
      default: state_s = IDLE;
    endcase
    if (grant_s) begin
      owner_s = win_s;
      addr_s  = win_s ? addr1 : addr0;
      we_s    = win_s ? we1 : we0;
      wdata_s = win_s ? wdata1 : wdata0;
    end else begin
      owner_s = owner_r;
    end
    if (!lock1 || (grant_s && !win_s)) begin
      lock_cnt_s = '0;
    end else if (grant_s && req0 && (lock_cnt_r < LOCK_MAX_C)) begin
      lock_cnt_s = lock_cnt_r + LOCK_ONE_C;
    end else begin
      lock_cnt_s = lock_cnt_r;
    end
  end

  // Control state; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= IDLE;
      owner_r    <= 1'b0;
      last_r     <= 1'b1;
      addr_r     <= '0;
      we_r       <= 1'b0;
      wdata_r    <= '0;
      lock_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      last_r     <= grant_s ? win_s : last_r;
      addr_r     <= addr_s;
      we_r       <= we_s;
      wdata_r    <= wdata_s;
      lock_cnt_r <= lock_cnt_s;
    end
  end

  // Output registers decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      err0_r      <= 1'b0;
      err1_r      <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      gnt0_r      <= (state_s != IDLE) && !owner_s;
      gnt1_r      <= (state_s != IDLE) && owner_s;
      ack0_r      <= (state_s == RESP) && !owner_s;
      ack1_r      <= (state_s == RESP) && owner_s;
      err0_r      <= (state_s == RESP) && !owner_s && !in_range(addr_s);
      err1_r      <= (state_s == RESP) && owner_s && !in_range(addr_s);
      mem_en_r    <= (state_s == ACCESS) && in_range(addr_s);
      mem_we_r    <= (state_s == ACCESS) && in_range(addr_s) && we_s;
      mem_addr_r  <= (state_s == ACCESS) ? addr_s : '0;
      mem_wdata_r <= (state_s == ACCESS) ? wdata_s : '0;
      busy_r      <= (state_s != IDLE);
    end
  end

  // Enables are gated by resetn so a reset during ACCESS never commits a write
  assign mem_en    = mem_en_r & resetn;
  assign mem_we    = mem_we_r & resetn;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign gnt0      = gnt0_r;
  assign gnt1      = gnt1_r;
  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign err0      = err0_r;
  assign err1      = err1_r;
  assign busy      = busy_r;
  assign rdata0    = (ack0_r && !we_r && !err0_r) ? mem_rdata : '0;
  assign rdata1    = (ack1_r && !we_r && !err1_r) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_dmem_port_arbiter;
  localparam int DW = 32, AW = 5, DEPTH = 20, MAX_LOCK = 4;

  logic          clk = 1'b0, resetn, preload;
  logic          req0, we0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
  logic          gnt0, gnt1, ack0, ack1, err0, err1, mem_en, mem_we, busy;
  logic [DW-1:0] env_mem   [32];
  logic [DW-1:0] model_mem [32];

  int checks = 0, errors = 0;
  bit check_en = 1'b0;

  // reference model: phase 0 idle, 1 memory access, 2 response
  int            m_ph = 0, m_own = 0, m_last = 1, m_cnt = 0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rd = '0;

  bit            e_inr, e_g0, e_g1, e_a0, e_a1, e_en;
  logic [8:0]    e_ctrl;

  dmem_port_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
    .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
    .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 3) ? 32'hDEADBEEF : 32'h1000_0000 + i;
  endfunction

  // memory the arbiter actually drives
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= init_val(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      else mem_rdata <= env_mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, want 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one clock of the reference model, using the inputs the DUT sees at this edge
  task automatic model_step();
    int win;
    bit e0, e1;
    if (!resetn) begin
      m_ph = 0; m_own = 0; m_last = 1; m_cnt = 0;
      m_addr = '0; m_we = 1'b0; m_wdata = '0;
    end else if (m_ph == 1) begin
      if (int'(m_addr) < DEPTH) begin
        if (m_we) model_mem[m_addr] = m_wdata;
        else m_rd = model_mem[m_addr];
      end
      m_ph = 2;
      if (!lock1) m_cnt = 0;
    end else begin
      e0 = req0 && !(m_ph == 2 && m_own == 0);
      e1 = req1 && !(m_ph == 2 && m_own == 1);
      if (m_own == 1 && lock1 && req1 && m_cnt < MAX_LOCK) win = e1 ? 1 : -1;
      else if (e0 && e1) win = 1 - m_last;
      else if (e0) win = 0;
      else if (e1) win = 1;
      else win = -1;
      if (!lock1 || win == 0) m_cnt = 0;
      else if (win == 1 && req0) m_cnt = (m_cnt + 1 > MAX_LOCK) ? MAX_LOCK : m_cnt + 1;
      if (win >= 0) begin
        m_own = win; m_last = win; m_ph = 1;
        if (win == 1) {m_addr, m_we, m_wdata} = {addr1, we1, wdata1};
        else {m_addr, m_we, m_wdata} = {addr0, we0, wdata0};
      end else begin
        m_ph = 0;
      end
    end
  endtask

  // compare every output against the model each cycle
  always @(negedge clk) begin
    if (check_en) begin
      e_inr  = int'(m_addr) < DEPTH;
      e_g0   = (m_ph != 0) && (m_own == 0);
      e_g1   = (m_ph != 0) && (m_own == 1);
      e_a0   = (m_ph == 2) && (m_own == 0);
      e_a1   = (m_ph == 2) && (m_own == 1);
      e_en   = (m_ph == 1) && e_inr && resetn;
      e_ctrl = {e_g0, e_g1, e_a0, e_a1, e_a0 && !e_inr, e_a1 && !e_inr, e_en, e_en && m_we, m_ph != 0};
      chk("ctrl{g0,g1,a0,a1,e0,e1,en,we,busy}",
          {23'd0, gnt0, gnt1, ack0, ack1, err0, err1, mem_en, mem_we, busy}, {23'd0, e_ctrl});
      chk("rdata0", rdata0, (e_a0 && !m_we && e_inr) ? m_rd : 32'd0);
      chk("rdata1", rdata1, (e_a1 && !m_we && e_inr) ? m_rd : 32'd0);
      chk("mem_addr", {27'd0, mem_addr}, (m_ph == 1) ? {27'd0, m_addr} : 32'd0);
      chk("mem_wdata", mem_wdata, (m_ph == 1) ? m_wdata : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic new_txn(input int p);
    if (p == 0) begin
      req0 = 1'b1; addr0 = AW'($urandom_range(0, 31)); we0 = 1'($urandom_range(0, 1)); wdata0 = $urandom;
    end else begin
      req1 = 1'b1; addr1 = AW'($urandom_range(0, 31)); we1 = 1'($urandom_range(0, 1)); wdata1 = $urandom;
    end
  endtask

  initial begin
    int acks, rises;
    bit prev, got;
    resetn = 1'b0; preload = 1'b1; lock1 = 1'b0;
    req0 = 1'b0; addr0 = '0; we0 = 1'b0; wdata0 = '0;
    req1 = 1'b0; addr1 = '0; we1 = 1'b0; wdata1 = '0;
    for (int i = 0; i < 32; i++) model_mem[i] = init_val(i);
    tick(); tick();
    preload = 1'b0; check_en = 1'b1;
    chk("reset_outputs", {23'd0, gnt0, gnt1, ack0, ack1, err0, err1, mem_en, mem_we, busy}, 32'd0);
    resetn = 1'b1;

    // 1: single read of addr 3
    req0 = 1'b1; addr0 = 5'd3; we0 = 1'b0;
    tick(); chk("t1_mem_en", {31'd0, mem_en}, 32'd1); chk("t1_mem_addr", {27'd0, mem_addr}, 32'd3);
    tick(); chk("t1_ack0", {31'd0, ack0}, 32'd1); chk("t1_rdata0", rdata0, 32'hDEADBEEF);
    chk("t1_err0", {31'd0, err0}, 32'd0);
    req0 = 1'b0; tick();

    // 2: simultaneous writes to addr 5, port 0 first
    do_reset();
    req0 = 1'b1; addr0 = 5'd5; we0 = 1'b1; wdata0 = 32'h11;
    req1 = 1'b1; addr1 = 5'd5; we1 = 1'b1; wdata1 = 32'h22;
    tick(); chk("t2_gnt0_first", {31'd0, gnt0}, 32'd1);
    tick(); chk("t2_ack0", {31'd0, ack0}, 32'd1); req0 = 1'b0;
    tick(); chk("t2_access1", {29'd0, gnt1, mem_en, mem_we}, 32'd7);
    tick(); chk("t2_ack1", {31'd0, ack1}, 32'd1); req1 = 1'b0;
    tick(); chk("t2_mem5", env_mem[5], 32'h22);

    // 3: both reading continuously, grants alternate
    do_reset();
    req0 = 1'b1; addr0 = 5'd1; we0 = 1'b0;
    req1 = 1'b1; addr1 = 5'd2; we1 = 1'b0;
    acks = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (ack0 || ack1) begin
        chk("t3_ack_port", {31'd0, ack1}, 32'(acks % 2));
        acks++;
      end
    end
    chk("t3_ack_count", acks, 32'd8);
    req0 = 1'b0; req1 = 1'b0; tick(); tick();

    // 4: bounded lock on port 1 while port 0 waits
    do_reset();
    lock1 = 1'b1; req1 = 1'b1; addr1 = 5'd6; we1 = 1'b0;
    tick(); chk("t4_first_gnt1", {31'd0, gnt1}, 32'd1);
    req0 = 1'b1; addr0 = 5'd7; we0 = 1'b0;
    rises = 0; prev = 1'b1; got = 1'b0;
    for (int c = 0; c < 80 && !got; c++) begin
      tick();
      if (gnt0) got = 1'b1;
      else if (gnt1 && !prev) rises++;
      prev = gnt1;
    end
    chk("t4_gnt0_reached", {31'd0, got}, 32'd1);
    chk("t4_locked_grants", rises, 32'd4);
    req1 = 1'b0; lock1 = 1'b0; got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin tick(); got = ack0; end
    chk("t4_ack0_seen", {31'd0, got}, 32'd1);
    req0 = 1'b0; tick();

    // 5: out-of-range write
    do_reset();
    req1 = 1'b1; addr1 = 5'd25; we1 = 1'b1; wdata1 = 32'h0000ABCD;
    tick(); chk("t5_access", {29'd0, gnt1, mem_en, mem_we}, 32'd4);
    tick(); chk("t5_ack_err", {30'd0, ack1, err1}, 32'd3); chk("t5_rdata1", rdata1, 32'd0);
    req1 = 1'b0;
    tick(); chk("t5_mem25", env_mem[25], 32'h1000_0019);

    // 6: reset during ACCESS of a write
    do_reset();
    req0 = 1'b1; addr0 = 5'd7; we0 = 1'b1; wdata0 = 32'h77;
    tick(); chk("t6_gnt0", {31'd0, gnt0}, 32'd1);
    resetn = 1'b0; req0 = 1'b0;
    tick(); chk("t6_outputs", {23'd0, gnt0, gnt1, ack0, ack1, err0, err1, mem_en, mem_we, busy}, 32'd0);
    chk("t6_mem7", env_mem[7], 32'h1000_0007);
    resetn = 1'b1; req1 = 1'b1; addr1 = 5'd3; we1 = 1'b0;
    tick(); tick();
    chk("t6_ack1", {31'd0, ack1}, 32'd1); chk("t6_rdata1", rdata1, 32'hDEADBEEF);
    req1 = 1'b0; tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (!resetn) begin
        resetn = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        resetn = 1'b0; req0 = 1'b0; req1 = 1'b0;
      end else begin
        if (req0 && ack0) begin
          if ($urandom_range(0, 1) == 1) new_txn(0); else req0 = 1'b0;
        end else if (!req0 && $urandom_range(0, 2) == 0) begin
          new_txn(0);
        end
        if (req1 && ack1) begin
          if ($urandom_range(0, 1) == 1) new_txn(1); else req1 = 1'b0;
        end else if (!req1 && $urandom_range(0, 2) == 0) begin
          new_txn(1);
        end
        if ($urandom_range(0, 7) == 0) lock1 = ~lock1;
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0; resetn = 1'b1;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
